// File: rtl/rf_pkg.sv
// Shared register-file definitions used by the writeback arbiter, the register
// file and the decode stage.
// Contents: address/data widths, the writeback entry layout, grant encoding.
package rf_pkg;

   localparam int AW = 5;
   localparam int DW = 32;

   // One pending register-file write: destination and value.
   typedef struct packed {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } wb_entry_t;

   // Which requester owns the write port this cycle.
   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_ALU  = 2'd1,
      GNT_LSU  = 2'd2
   } wb_grant_e;

endpackage

// File: rtl/rf_wb_hold.sv
// Purpose: one-entry writeback holding register; writes to x0 are accepted and dropped.
// Latency: an accepted entry is visible on hold_* the cycle after the accepting edge.
// Backpressure: ready is low only while the entry is held and not granted this cycle.
// Ports: clk/rst_n; valid/ready/rd/data from upstream; grant from the arbiter;
//        hold_v/hold_rd/hold_data to the arbiter; load pulses when a non-x0 entry is captured.
module rf_wb_hold #(
   parameter int AW = rf_pkg::AW,
   parameter int DW = rf_pkg::DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          valid,
   output logic          ready,
   input  logic [AW-1:0] rd,
   input  logic [DW-1:0] data,
   input  logic          grant,
   output logic          hold_v,
   output logic [AW-1:0] hold_rd,
   output logic [DW-1:0] hold_data,
   output logic          load
);
   import rf_pkg::*;

   logic accept;

   // Ready includes rst_n so nothing is taken while reset is asserted, and it
   // never looks at valid so upstream can use it to decide whether to present.
   assign ready  = rst_n && (!hold_v || grant);
   assign accept = valid && ready;
   // An x0 entry completes the handshake but never occupies the register.
   assign load   = accept && (rd != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_v    <= 1'b0;
         hold_rd   <= '0;
         hold_data <= '0;
      end else begin
         if (load) begin
            hold_v    <= 1'b1;
            hold_rd   <= rd;
            hold_data <= data;
         end else if (grant) begin
            hold_v    <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Purpose: shares the register-file write port between the ALU and LSU writeback paths.
// Latency: one edge from accept to register-file write when uncontended.
// Backpressure: the losing requester's ready stays low until it is granted.
// Ports: alu_*/lsu_* valid/ready request channels; rf_we/rf_waddr/rf_wdata drive the
//        register file; pend_mask flags registers with a held write for decode stalls.
// Build option: RF_WB_RR_EN selects round-robin between requesters instead of
//        fixed LSU priority with the STARVE_MAX starvation counter.
module rf_wb_arbiter #(
   parameter int AW         = rf_pkg::AW,
   parameter int DW         = rf_pkg::DW,
   parameter int STARVE_MAX = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                alu_valid,
   output logic                alu_ready,
   input  logic [AW-1:0]       alu_rd,
   input  logic [DW-1:0]       alu_data,
   input  logic                lsu_valid,
   output logic                lsu_ready,
   input  logic [AW-1:0]       lsu_rd,
   input  logic [DW-1:0]       lsu_data,
   output logic                rf_we,
   output logic [AW-1:0]       rf_waddr,
   output logic [DW-1:0]       rf_wdata,
   output logic [(1<<AW)-1:0]  pend_mask
);
   import rf_pkg::*;

   logic          alu_hv, lsu_hv;
   logic [AW-1:0] alu_hrd, lsu_hrd;
   logic [DW-1:0] alu_hdata, lsu_hdata;
   logic          alu_load, lsu_load;
   logic          alu_grant, lsu_grant;
   logic          same_rd;
   logic          alu_older;
   logic          alu_favoured;
   wb_grant_e     gnt;

   rf_wb_hold #(.AW(AW), .DW(DW)) u_alu_hold (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid     (alu_valid),
      .ready     (alu_ready),
      .rd        (alu_rd),
      .data      (alu_data),
      .grant     (alu_grant),
      .hold_v    (alu_hv),
      .hold_rd   (alu_hrd),
      .hold_data (alu_hdata),
      .load      (alu_load)
   );

   rf_wb_hold #(.AW(AW), .DW(DW)) u_lsu_hold (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid     (lsu_valid),
      .ready     (lsu_ready),
      .rd        (lsu_rd),
      .data      (lsu_data),
      .grant     (lsu_grant),
      .hold_v    (lsu_hv),
      .hold_rd   (lsu_hrd),
      .hold_data (lsu_hdata),
      .load      (lsu_load)
   );

   assign same_rd = alu_hv && lsu_hv && (alu_hrd == lsu_hrd);

   // Age bit: set when the ALU entry is the older of the two. A fresh ALU
   // load is never older; a lone LSU load leaves any held ALU entry older.
   // Simultaneous loads clear it, so the LSU entry counts as older.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_older <= 1'b0;
      end else if (alu_load) begin
         alu_older <= 1'b0;
      end else if (lsu_load) begin
         alu_older <= 1'b1;
      end
   end

`ifdef RF_WB_RR_EN
   logic rr_alu;

   assign alu_favoured = rr_alu;

   // After any cycle where both entries competed, favour whoever lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_alu <= 1'b0;
      end else if (alu_hv && lsu_hv) begin
         rr_alu <= lsu_grant;
      end
   end
`else
   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [CW-1:0] starve_cnt;

   assign alu_favoured = (starve_cnt == CW'(STARVE_MAX));

   // Counts consecutive lost cycles for a held ALU entry; it saturates rather
   // than wraps so a same-rd override cannot reset the ALU's claim.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!alu_hv || alu_grant) begin
         starve_cnt <= '0;
      end else if (!alu_favoured) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`endif

   // Same-destination ordering beats both priority and starvation.
   always_comb begin
      gnt = GNT_NONE;
      if (alu_hv && lsu_hv) begin
         if (same_rd) begin
            gnt = alu_older ? GNT_ALU : GNT_LSU;
         end else begin
            gnt = alu_favoured ? GNT_ALU : GNT_LSU;
         end
      end else if (alu_hv) begin
         gnt = GNT_ALU;
      end else if (lsu_hv) begin
         gnt = GNT_LSU;
      end
   end

   assign alu_grant = (gnt == GNT_ALU);
   assign lsu_grant = (gnt == GNT_LSU);

   // Driven straight from the async-reset holds, so reset drops rf_we at once.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      if (alu_grant) begin
         rf_we    = 1'b1;
         rf_waddr = alu_hrd;
         rf_wdata = alu_hdata;
      end else if (lsu_grant) begin
         rf_we    = 1'b1;
         rf_waddr = lsu_hrd;
         rf_wdata = lsu_hdata;
      end
   end

   always_comb begin
      pend_mask = '0;
      if (alu_hv) begin
         pend_mask[alu_hrd] = 1'b1;
      end
      if (lsu_hv) begin
         pend_mask[lsu_hrd] = 1'b1;
      end
      // x0 is hardwired; decode must never stall on it.
      pend_mask[0] = 1'b0;
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus random traffic,
// every cycle compared against a queue/sequence-number reference model.
module tb_rf_wb_arbiter;
   import rf_pkg::*;

   localparam int SM = 3;
`ifdef RF_WB_RR_EN
   localparam int WIN1 = 2;
   localparam int WIN2 = 4;
`else
   localparam int WIN1 = SM + 1;
   localparam int WIN2 = 2 * SM + 2;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          alu_valid = 1'b0;
   logic          alu_ready;
   logic [AW-1:0] alu_rd = '0;
   logic [DW-1:0] alu_data = '0;
   logic          lsu_valid = 1'b0;
   logic          lsu_ready;
   logic [AW-1:0] lsu_rd = '0;
   logic [DW-1:0] lsu_data = '0;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [31:0]   pend_mask;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .pend_mask (pend_mask)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: index 0 = ALU, 1 = LSU. Age is a global load sequence number.
   logic          m_v [2];
   logic [AW-1:0] m_rd [2];
   logic [DW-1:0] m_data [2];
   int            m_seq [2];
   int            seq_ctr;
`ifdef RF_WB_RR_EN
   logic          m_fav_alu;
`else
   int            m_lost;
`endif

   wb_entry_t     wlog [$];
   int            pend_cycles;
   logic          s_alu_ready, s_lsu_ready, s_we;
   logic [AW-1:0] s_waddr;
   logic [DW-1:0] s_wdata;
   logic [31:0]   s_pm;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_v[i]    = 1'b0;
         m_rd[i]   = '0;
         m_data[i] = '0;
         m_seq[i]  = 0;
      end
      seq_ctr = 0;
`ifdef RF_WB_RR_EN
      m_fav_alu = 1'b0;
`else
      m_lost = 0;
`endif
   endtask

   // -1: no write, 0: ALU writes, 1: LSU writes.
   function automatic int model_grant();
      if (m_v[0] && m_v[1]) begin
         if (m_rd[0] == m_rd[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
`ifdef RF_WB_RR_EN
         return m_fav_alu ? 0 : 1;
`else
         return (m_lost >= SM) ? 0 : 1;
`endif
      end
      if (m_v[0]) return 0;
      if (m_v[1]) return 1;
      return -1;
   endfunction

   // One clock: compare at the falling edge, advance the model, return just after the rising edge.
   task automatic cycle();
      int            g;
      logic          e_ra, e_rl, e_we;
      logic [AW-1:0] e_wa;
      logic [DW-1:0] e_wd;
      logic [31:0]   e_pm;
      @(negedge clk);
      g    = model_grant();
      e_ra = rst_n && (!m_v[0] || g == 0);
      e_rl = rst_n && (!m_v[1] || g == 1);
      e_we = (g >= 0);
      e_wa = (g >= 0) ? m_rd[g] : '0;
      e_wd = (g >= 0) ? m_data[g] : '0;
      e_pm = '0;
      for (int i = 0; i < 2; i++) if (m_v[i]) e_pm[m_rd[i]] = 1'b1;
      e_pm[0] = 1'b0;

      s_alu_ready = alu_ready;
      s_lsu_ready = lsu_ready;
      s_we        = rf_we;
      s_waddr     = rf_waddr;
      s_wdata     = rf_wdata;
      s_pm        = pend_mask;
      if (rf_we) wlog.push_back('{rd: rf_waddr, data: rf_wdata});
      if (pend_mask != '0) pend_cycles++;

      chk("alu_ready", alu_ready, e_ra);
      chk("lsu_ready", lsu_ready, e_rl);
      chk("rf_we", rf_we, e_we);
      chk("rf_waddr", rf_waddr, e_wa);
      chk("rf_wdata", rf_wdata, e_wd);
      chk("pend_mask", pend_mask, e_pm);

      if (!rst_n) begin
         model_reset();
      end else begin
`ifdef RF_WB_RR_EN
         if (m_v[0] && m_v[1]) m_fav_alu = (g == 1);
`else
         if (m_v[0] && g != 0) m_lost = (m_lost < SM) ? m_lost + 1 : SM;
         else m_lost = 0;
`endif
         if (g >= 0) m_v[g] = 1'b0;
         if (lsu_valid && e_rl && lsu_rd != '0) begin
            m_v[1] = 1'b1; m_rd[1] = lsu_rd; m_data[1] = lsu_data; m_seq[1] = seq_ctr;
            seq_ctr++;
         end
         if (alu_valid && e_ra && alu_rd != '0) begin
            m_v[0] = 1'b1; m_rd[0] = alu_rd; m_data[0] = alu_data; m_seq[0] = seq_ctr;
            seq_ctr++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      alu_valid = 1'b0;
      lsu_valid = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic clear_log();
      wlog.delete();
      pend_cycles = 0;
   endtask

   initial begin
      int first_win, second_win;
      model_reset();
      clear_log();

      // Reset state, then release: both readies rise in the first cycle.
      cycle();
      cycle();
      chk("reset_we", s_we, 1'b0);
      rst_n = 1'b1;
      cycle();
      chk("release_alu_ready", s_alu_ready, 1'b1);
      chk("release_lsu_ready", s_lsu_ready, 1'b1);

      // Single ALU write.
      clear_log();
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      cycle();
      alu_valid = 1'b0;
      cycle();
      chk("alu1_we", s_we, 1'b1);
      chk("alu1_waddr", s_waddr, 5);
      chk("alu1_wdata", s_wdata, 32'hDEADBEEF);
      chk("alu1_pend5", s_pm[5], 1'b1);
      idle(2);
      chk("alu1_writes", wlog.size(), 1);
      chk("alu1_pend_cycles", pend_cycles, 1);

      // x0 drop.
      clear_log();
      lsu_valid = 1'b1; lsu_rd = '0; lsu_data = 32'h1234;
      cycle();
      chk("x0_lsu_ready", s_lsu_ready, 1'b1);
      idle(3);
      chk("x0_writes", wlog.size(), 0);
      chk("x0_pend_cycles", pend_cycles, 0);

      // Simultaneous, different rd: LSU first, ALU waits one cycle.
      clear_log();
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
      cycle();
      alu_valid = 1'b0; lsu_valid = 1'b0;
      cycle();
      chk("simul_first_waddr", s_waddr, 4);
      chk("simul_alu_ready_low", s_alu_ready, 1'b0);
      cycle();
      chk("simul_second_waddr", s_waddr, 3);
      chk("simul_alu_ready_back", s_alu_ready, 1'b1);
      idle(2);

      // Same rd, LSU loaded first.
      clear_log();
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hA;
      cycle();
      lsu_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hB;
      cycle();
      idle(3);
      chk("samerd_a_writes", wlog.size(), 2);
      if (wlog.size() == 2) begin
         chk("samerd_a_first", wlog[0].data, 32'hA);
         chk("samerd_a_second", wlog[1].data, 32'hB);
      end

      // Same rd, ALU older but blocked: the younger LSU entry must wait despite priority.
      clear_log();
      lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'h1;
      alu_valid = 1'b1; alu_rd = 5'd7;  alu_data = 32'hB;
      cycle();
      alu_valid = 1'b0;
      lsu_rd = 5'd7; lsu_data = 32'hA;
      cycle();
      lsu_valid = 1'b0;
      idle(3);
      chk("samerd_b_writes", wlog.size(), 3);
      if (wlog.size() == 3) begin
         chk("samerd_b_w0_rd", wlog[0].rd, 12);
         chk("samerd_b_w1_data", wlog[1].data, 32'hB);
         chk("samerd_b_w2_data", wlog[2].data, 32'hA);
      end

      // Starvation / round-robin: LSU streams varying rd, ALU keeps targeting x9.
      clear_log();
      first_win = -1; second_win = -1;
      alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'h900;
      lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = $urandom;
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (s_we && s_waddr == 5'd9) begin
            if (first_win < 0) first_win = k;
            else if (second_win < 0) second_win = k;
         end
         if (s_alu_ready) alu_data = alu_data + 1;
         if (s_lsu_ready) begin
            lsu_rd = AW'(10 + (k % 8));
            lsu_data = $urandom;
         end
      end
      chk("starve_first_alu_win", first_win, WIN1);
      chk("starve_second_alu_win", second_win, WIN2);
      idle(3);

      // Reset mid-operation with both holds occupied.
      alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h2020;
      lsu_valid = 1'b1; lsu_rd = 5'd21; lsu_data = 32'h2121;
      cycle();
      alu_valid = 1'b0; lsu_valid = 1'b0;
      #2;
      chk("midrst_pre_we", rf_we, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst_we_async", rf_we, 1'b0);
      chk("midrst_pend", pend_mask, 32'h0);
      chk("midrst_alu_ready", alu_ready, 1'b0);
      chk("midrst_lsu_ready", lsu_ready, 1'b0);
      model_reset();
      clear_log();
      cycle();
      rst_n = 1'b1;
      idle(3);
      chk("midrst_no_writes", wlog.size(), 0);

      // Random traffic; upstream holds each entry until accepted.
      for (int k = 0; k < 500; k++) begin
         if (!alu_valid || s_alu_ready) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            alu_rd    = AW'($urandom_range(0, 7));
            alu_data  = $urandom;
         end
         if (!lsu_valid || s_lsu_ready) begin
            lsu_valid = ($urandom_range(0, 99) < 60);
            lsu_rd    = AW'($urandom_range(0, 7));
            lsu_data  = $urandom;
         end
         cycle();
      end
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
